// File: rtl/wb_result_arbiter_if.sv
// wb_result_arbiter_if: producer-side and writeback-side signals of the result arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the execution units
// and the register file.
interface wb_result_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
);
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*RD_W-1:0]   in_rd;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     wb_ready;
  logic                     wb_valid;
  logic [RD_W-1:0]          wb_rd;
  logic [DATA_W-1:0]        wb_data;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        ovf;

  modport slave (
    input  in_valid, in_rd, in_data, wb_ready,
    output in_ready, wb_valid, wb_rd, wb_data, busy, ovf
  );

  modport master (
    output in_valid, in_rd, in_data, wb_ready,
    input  in_ready, wb_valid, wb_rd, wb_data, busy, ovf
  );
endinterface

// File: rtl/wb_result_arbiter.sv
// wb_result_arbiter: per-channel {Rd, result} FIFOs that drain into one registered writeback port.
// Arbitration mode is selected by the macro WB_ARB_ROUND_ROBIN_EN:
//   undefined -> fixed priority, the highest busy channel wins.
//   defined   -> round robin, the search starts at the RR pointer and moves upward.
// A full FIFO refuses a push even when it pops in the same cycle. A refused push sets the sticky ovf bit.
module wb_result_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int RD_W   = 4,
  parameter int DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_result_arbiter_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [RD_W-1:0]   rd_mem_q   [NUM_CH][DEPTH];
  logic [DATA_W-1:0] data_mem_q [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q   [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;

  logic              wb_valid_q;
  logic [RD_W-1:0]   wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] not_empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] pop;
  logic              load;
  logic              grant_vld;
  logic [CH_W-1:0]   gnt_idx;

  // Occupancy flags are derived only from the counters, never from this cycle's pop.
  always_comb begin
    full      = '0;
    not_empty = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      full[i]      = (cnt_q[i] == CNT_W'(DEPTH));
      not_empty[i] = (cnt_q[i] != '0);
    end
  end

  assign push      = bus.in_valid & ~full;
  assign drop      = bus.in_valid & full;
  assign load      = ~wb_valid_q | bus.wb_ready;
  assign grant_vld = load & (|not_empty);

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [CH_W-1:0] rr_ptr_q;
  logic [CH_W-1:0] rr_ptr_d;
  logic [CH_W-1:0] cand;

  // Round robin: scan downward from the farthest candidate so the nearest busy one is taken last.
  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
      if (not_empty[cand]) begin
        gnt_idx = cand;
      end
    end
  end

  // The pointer moves to the channel just past the one granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // RR pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority: the highest busy index wins because the loop ascends.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (not_empty[i]) begin
        gnt_idx = CH_W'(i);
      end
    end
  end
`endif

  // One-hot pop toward the granted FIFO
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = grant_vld && (gnt_idx == CH_W'(i));
    end
  end

  // FIFO pointers, occupancy and sticky overflow. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        end
        if (push[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (pop[i] && !push[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
        if (drop[i]) begin
          ovf_q[i] <= 1'b1;
        end
      end
    end
  end

  // FIFO storage. Contents are left unreset because the counters decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        rd_mem_q[i][wr_ptr_q[i]]   <= bus.in_rd[i*RD_W +: RD_W];
        data_mem_q[i][wr_ptr_q[i]] <= bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writeback register. It holds its payload when idle or stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else if (load) begin
      wb_valid_q <= grant_vld;
      if (grant_vld) begin
        wb_rd_q   <= rd_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
        wb_data_q <= data_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
      end
    end
  end

  assign bus.in_ready = ~full;
  assign bus.busy     = not_empty;
  assign bus.ovf      = ovf_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;

endmodule
